// File: rtl/fft_peak_classifier.sv
// fft_peak_classifier: single-pass scan of the FFT magnitude RAM that keeps the
// NUM_PEAKS largest non-carrier bins in a sorted list, reads the carrier bin and
// classifies the spectrum as none / AM / FM / unmodulated carrier.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             level; a rising edge in IDLE launches a scan
//   clear             one-cycle pulse; aborts a run or leaves DONE
//   rd_data           RAM read data, valid RD_LAT cycles after rd_addr
//   rd_addr           RAM read address
//   mode_type         000 none, 001 AM, 010 FM, 100 unmodulated
//   carrier_mag       magnitude read at CARRIER_ADDR
//   spacing           |bin of strongest peak - CARRIER_ADDR|
//   busy              high in SCAN, DRAIN, CAR, JUDGE
//   valid             high in DONE; results stable while high
module fft_peak_classifier #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned NUM_PEAKS    = 4,
    parameter int unsigned CARRIER_ADDR = 100,
    parameter int unsigned SCAN_END     = 201,
    parameter int unsigned NOISE_TH     = 100,
    parameter int unsigned RATIO_SHIFT  = 3,
    parameter int unsigned RD_LAT       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [2:0]        mode_type,
    output logic [DATA_W-1:0] carrier_mag,
    output logic [ADDR_W-1:0] spacing,
    output logic              busy,
    output logic              valid
);

    localparam int unsigned SH_W   = DATA_W + RATIO_SHIFT;
    localparam int unsigned SUM_W  = ADDR_W + 1;
    localparam int unsigned DCNT_W = 2;
    localparam logic [ADDR_W-1:0] CAR_A = ADDR_W'(CARRIER_ADDR);
    localparam logic [ADDR_W-1:0] END_A = ADDR_W'(SCAN_END);
    localparam logic [DATA_W-1:0] TH    = DATA_W'(NOISE_TH);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_DRAIN, S_CAR, S_JUDGE, S_DONE
    } state_t;

    state_t state, state_nx;

    logic              start_d;
    logic              start_edge;
    logic [DCNT_W-1:0] drain_cnt, drain_nx;
    logic [ADDR_W-1:0] rd_addr_nx, spacing_nx;
    logic [2:0]        mode_nx;
    logic [DATA_W-1:0] car_nx;
    logic              busy_nx, valid_nx, clr_list;

    logic [DATA_W-1:0] pk_mag    [NUM_PEAKS];
    logic [ADDR_W-1:0] pk_bin    [NUM_PEAKS];
    logic [DATA_W-1:0] pk_mag_nx [NUM_PEAKS];
    logic [ADDR_W-1:0] pk_bin_nx [NUM_PEAKS];
    logic [NUM_PEAKS-1:0] gt;

    logic [ADDR_W-1:0] tag_addr [RD_LAT];
    logic              tag_vld  [RD_LAT];
    logic              do_ins;
    logic [ADDR_W-1:0] samp_bin;

    logic [2:0]        judge_mode;
    logic [ADDR_W-1:0] judge_spacing;

    assign start_edge = start & ~start_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx   = state;
        rd_addr_nx = rd_addr;
        mode_nx    = mode_type;
        car_nx     = carrier_mag;
        spacing_nx = spacing;
        drain_nx   = drain_cnt;
        clr_list   = 1'b0;
        case (state)
            S_IDLE: begin
                rd_addr_nx = '0;
                if (start_edge && !clear) begin
                    state_nx = S_SCAN;
                    clr_list = 1'b1;
                end
            end
            S_SCAN: begin
                if (rd_addr == END_A) begin
                    rd_addr_nx = CAR_A;
                    drain_nx   = '0;
                    state_nx   = S_DRAIN;
                end else begin
                    rd_addr_nx = rd_addr + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DCNT_W'(RD_LAT - 1)) state_nx = S_CAR;
                else drain_nx = drain_cnt + DCNT_W'(1);
            end
            S_CAR: begin
                car_nx   = rd_data;
                state_nx = S_JUDGE;
            end
            S_JUDGE: begin
                mode_nx    = judge_mode;
                spacing_nx = judge_spacing;
                state_nx   = S_DONE;
            end
            S_DONE: ;
            default: state_nx = S_IDLE;
        endcase
        if (clear && state != S_IDLE) begin
            state_nx   = S_IDLE;
            rd_addr_nx = '0;
        end
        busy_nx  = (state_nx == S_SCAN) || (state_nx == S_DRAIN) ||
                   (state_nx == S_CAR)  || (state_nx == S_JUDGE);
        valid_nx = (state_nx == S_DONE);
    end

    // Classification from the sorted list and the latched carrier magnitude
    always_comb begin
        logic [SH_W-1:0]  sh0, sh1, car_w;
        logic [SUM_W-1:0] bin_avg;
        logic             fm_ok;
        sh0     = SH_W'(pk_mag[0]) << RATIO_SHIFT;
        sh1     = SH_W'(pk_mag[1]) << RATIO_SHIFT;
        car_w   = SH_W'(carrier_mag);
        bin_avg = (SUM_W'(pk_bin[0]) + SUM_W'(pk_bin[1])) >> 1;
        fm_ok   = 1'b1;
        for (int i = 2; i < NUM_PEAKS; i++) begin
            if (pk_mag[i] <= TH) fm_ok = 1'b0;
        end
        if (carrier_mag <= TH && pk_mag[0] <= TH)                     judge_mode = 3'b000;
        else if (fm_ok)                                               judge_mode = 3'b010;
        else if (sh0 >= car_w && sh1 >= car_w &&
                 bin_avg == SUM_W'(CARRIER_ADDR))                     judge_mode = 3'b001;
        else                                                          judge_mode = 3'b100;
        judge_spacing = (pk_bin[0] >= CAR_A) ? (pk_bin[0] - CAR_A) : (CAR_A - pk_bin[0]);
    end

    // Sorted insertion; gt[] is monotonic because the list is kept descending
    assign samp_bin = tag_addr[RD_LAT-1];
    assign do_ins   = tag_vld[RD_LAT-1] && (state == S_SCAN || state == S_DRAIN) &&
                      (samp_bin != CAR_A) && (rd_data != '0);

    always_comb begin
        for (int i = 0; i < NUM_PEAKS; i++) begin
            gt[i]        = rd_data > pk_mag[i];
            pk_mag_nx[i] = pk_mag[i];
            pk_bin_nx[i] = pk_bin[i];
        end
        if (clr_list) begin
            for (int i = 0; i < NUM_PEAKS; i++) begin
                pk_mag_nx[i] = '0;
                pk_bin_nx[i] = '0;
            end
        end else if (do_ins) begin
            if (gt[0]) begin
                pk_mag_nx[0] = rd_data;
                pk_bin_nx[0] = samp_bin;
            end
            for (int i = 1; i < NUM_PEAKS; i++) begin
                if (gt[i] && gt[i-1]) begin
                    pk_mag_nx[i] = pk_mag[i-1];
                    pk_bin_nx[i] = pk_bin[i-1];
                end else if (gt[i]) begin
                    pk_mag_nx[i] = rd_data;
                    pk_bin_nx[i] = samp_bin;
                end
            end
        end
    end

    // Datapath and output registers; tag pipeline is flushed while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_d     <= 1'b0;
            rd_addr     <= '0;
            mode_type   <= '0;
            carrier_mag <= '0;
            spacing     <= '0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            drain_cnt   <= '0;
            for (int i = 0; i < NUM_PEAKS; i++) begin
                pk_mag[i] <= '0;
                pk_bin[i] <= '0;
            end
            for (int i = 0; i < RD_LAT; i++) begin
                tag_addr[i] <= '0;
                tag_vld[i]  <= 1'b0;
            end
        end else begin
            start_d     <= start;
            rd_addr     <= rd_addr_nx;
            mode_type   <= mode_nx;
            carrier_mag <= car_nx;
            spacing     <= spacing_nx;
            busy        <= busy_nx;
            valid       <= valid_nx;
            drain_cnt   <= drain_nx;
            for (int i = 0; i < NUM_PEAKS; i++) begin
                pk_mag[i] <= pk_mag_nx[i];
                pk_bin[i] <= pk_bin_nx[i];
            end
            tag_addr[0] <= rd_addr;
            tag_vld[0]  <= (state == S_SCAN);
            for (int i = 1; i < RD_LAT; i++) begin
                tag_addr[i] <= tag_addr[i-1];
                tag_vld[i]  <= (state == S_IDLE) ? 1'b0 : tag_vld[i-1];
            end
        end
    end

endmodule
